// File: rtl/alu_mem_unit_if.sv
// Signal bundle between the single-cycle datapath and the execute/memory slice.
// There is no valid/ready handshake: the datapath holds every input stable across the clock edge.
interface alu_mem_unit_if;
  logic [1:0]  alu_op;
  logic [5:0]  func_code;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] read_data;

  modport master (
    output alu_op, func_code, alu_in_a, alu_in_b, mem_read, mem_write, write_data,
    input  alu_ctrl, alu_out, zero, read_data
  );

  modport slave (
    input  alu_op, func_code, alu_in_a, alu_in_b, mem_read, mem_write, write_data,
    output alu_ctrl, alu_out, zero, read_data
  );
endinterface

// File: rtl/alu_mem_unit.sv
// Execute/memory slice: ALU-control decode, 32-bit ALU with zero flag, and a
// word-organised data memory addressed by the ALU result.
module alu_mem_unit #(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_mem_unit_if.slave  bus
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_INV = 4'b1111;

  localparam int DEPTH = 1 << ADDR_W;

  logic [3:0]        w_alu_ctrl;
  logic [31:0]       w_alu_out;
  logic [ADDR_W-1:0] w_index;
  logic [31:0]       r_mem [DEPTH];

  always_comb begin
    w_alu_ctrl = CTRL_INV;
    case (bus.alu_op)
      2'b00: w_alu_ctrl = CTRL_ADD;
      2'b01: w_alu_ctrl = CTRL_SUB;
      2'b11: w_alu_ctrl = CTRL_OR;
      default: begin
        case (bus.func_code)
          6'b100000: w_alu_ctrl = CTRL_ADD;
          6'b100010: w_alu_ctrl = CTRL_SUB;
          6'b100100: w_alu_ctrl = CTRL_AND;
          6'b100101: w_alu_ctrl = CTRL_OR;
          6'b100111: w_alu_ctrl = CTRL_NOR;
          6'b101010: w_alu_ctrl = CTRL_SLT;
          default:   w_alu_ctrl = CTRL_INV;
        endcase
      end
    endcase
  end

  // Unsupported codes produce 0, which deliberately raises zero.
  always_comb begin
    w_alu_out = 32'd0;
    case (w_alu_ctrl)
      CTRL_AND: w_alu_out = bus.alu_in_a & bus.alu_in_b;
      CTRL_OR:  w_alu_out = bus.alu_in_a | bus.alu_in_b;
      CTRL_ADD: w_alu_out = bus.alu_in_a + bus.alu_in_b;
      CTRL_SUB: w_alu_out = bus.alu_in_a - bus.alu_in_b;
      CTRL_NOR: w_alu_out = ~(bus.alu_in_a | bus.alu_in_b);
      CTRL_SLT: w_alu_out = ($signed(bus.alu_in_a) < $signed(bus.alu_in_b)) ? 32'd1 : 32'd0;
      default:  w_alu_out = 32'd0;
    endcase
  end

  // Byte-offset bits and bits above the array size are dropped, so addresses wrap.
  assign w_index = w_alu_out[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (bus.mem_write) begin
      r_mem[w_index] <= bus.write_data;
    end
  end

  assign bus.alu_ctrl  = w_alu_ctrl;
  assign bus.alu_out   = w_alu_out;
  assign bus.zero      = (w_alu_out == 32'd0);
  assign bus.read_data = bus.mem_read ? r_mem[w_index] : 32'd0;

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed bench for alu_mem_unit: decode, ALU, zero flag, memory store/load,
// address wrap and reset behaviour against hand-computed values.
module tb_alu_mem_unit;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  alu_mem_unit_if bus ();

  alu_mem_unit #(.ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op    = op;
    bus.func_code = fn;
    bus.alu_in_a  = a;
    bus.alu_in_b  = b;
  endtask

  task automatic alu_case(input string tag, input logic [5:0] fn,
                          input logic [3:0] exp_ctrl, input logic [31:0] exp_out);
    drive(2'b10, fn, 32'h0000000C, 32'h0000000A);
    @(negedge clk);
    check({tag, "_ctrl"}, {28'd0, bus.alu_ctrl}, {28'd0, exp_ctrl});
    check({tag, "_out"}, bus.alu_out, exp_out);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.write_data = 32'd0;
    drive(2'b00, 6'd0, 32'd0, 32'h40);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed a word, then clear it with an asynchronous pulse between edges.
    bus.write_data = 32'h00000055;
    bus.mem_write  = 1'b1;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b1;
    #1;
    check("seed_0x40", bus.read_data, 32'h00000055);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_alu_out", bus.alu_out, 32'h40);
    check("rst_rd_0x40", bus.read_data, 32'd0);
    drive(2'b00, 6'd0, 32'd0, 32'h0);
    @(negedge clk);
    check("rst_rd_0x00", bus.read_data, 32'd0);
    drive(2'b00, 6'd0, 32'd0, 32'h3FC);
    @(negedge clk);
    check("rst_rd_0x3fc", bus.read_data, 32'd0);
    bus.mem_read = 1'b0;

    alu_case("r_add", 6'b100000, 4'b0010, 32'h00000016);
    alu_case("r_sub", 6'b100010, 4'b0110, 32'h00000002);
    alu_case("r_and", 6'b100100, 4'b0000, 32'h00000008);
    alu_case("r_or",  6'b100101, 4'b0001, 32'h0000000E);
    alu_case("r_nor", 6'b100111, 4'b1100, 32'hFFFFFFF1);
    alu_case("r_slt", 6'b101010, 4'b0111, 32'h00000000);

    drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
    @(negedge clk);
    check("slt_neg_lt", bus.alu_out, 32'd1);
    drive(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF);
    @(negedge clk);
    check("slt_pos_ge", bus.alu_out, 32'd0);

    drive(2'b10, 6'b000000, 32'h0000000C, 32'h0000000A);
    @(negedge clk);
    check("inv_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
    check("inv_out", bus.alu_out, 32'd0);
    check("inv_zero", {31'd0, bus.zero}, 32'd1);

    drive(2'b11, 6'b100000, 32'h000000F0, 32'h0000000F);
    @(negedge clk);
    check("ori_ctrl", {28'd0, bus.alu_ctrl}, 32'h1);
    check("ori_out", bus.alu_out, 32'h000000FF);

    drive(2'b01, 6'd0, 32'h1234, 32'h1234);
    @(negedge clk);
    check("beq_eq_out", bus.alu_out, 32'd0);
    check("beq_eq_zero", {31'd0, bus.zero}, 32'd1);
    drive(2'b01, 6'd0, 32'h1235, 32'h1234);
    @(negedge clk);
    check("beq_ne_out", bus.alu_out, 32'd1);
    check("beq_ne_zero", {31'd0, bus.zero}, 32'd0);

    drive(2'b00, 6'd0, 32'hFFFFFFFF, 32'h1);
    @(negedge clk);
    check("add_wrap_out", bus.alu_out, 32'd0);
    check("add_wrap_zero", {31'd0, bus.zero}, 32'd1);

    // Store with read enabled: old value before the edge, new value after.
    drive(2'b00, 6'd0, 32'h100, 32'h8);
    bus.write_data = 32'hDEADBEEF;
    bus.mem_write  = 1'b1;
    bus.mem_read   = 1'b1;
    #1;
    check("st_before_edge", bus.read_data, 32'd0);
    @(posedge clk); #1;
    check("st_after_edge", bus.read_data, 32'hDEADBEEF);
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("ld_0x108", bus.read_data, 32'hDEADBEEF);
    drive(2'b00, 6'd0, 32'h100, 32'hB);
    @(negedge clk);
    check("ld_0x10b", bus.read_data, 32'hDEADBEEF);
    drive(2'b00, 6'd0, 32'h500, 32'h8);
    @(negedge clk);
    check("ld_wrap_0x508", bus.read_data, 32'hDEADBEEF);
    drive(2'b00, 6'd0, 32'h100, 32'h4);
    @(negedge clk);
    check("ld_0x104_empty", bus.read_data, 32'd0);
    drive(2'b00, 6'd0, 32'h100, 32'h8);
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("rd_disabled", bus.read_data, 32'd0);

    // Write attempted while reset is held across an edge.
    rst_n          = 1'b0;
    bus.write_data = 32'h12345678;
    bus.mem_write  = 1'b1;
    drive(2'b00, 6'd0, 32'h200, 32'h10);
    @(posedge clk); #1;
    @(negedge clk);
    bus.mem_write = 1'b0;
    rst_n         = 1'b1;
    bus.mem_read  = 1'b1;
    #1;
    check("rst_wr_blocked", bus.read_data, 32'd0);
    drive(2'b00, 6'd0, 32'h100, 32'h8);
    #1;
    check("rst_cleared_0x108", bus.read_data, 32'd0);

    // Ordinary write after release still works.
    bus.write_data = 32'hA5A5A5A5;
    bus.mem_write  = 1'b1;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("post_rst_write", bus.read_data, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mem_unit.md
# alu_mem_unit

Execute/memory datapath slice of the single-cycle MIPS-style processor. It combines three functions: ALU-control decoding from the 2-bit main-control ALU op and the instruction funct field, a 32-bit ALU with zero flag, and a word-organised data memory addressed by the ALU result. It sits between the register file / ALUsrc mux and the MemtoReg mux.

## Interface
Parameters:
- ADDR_W, default 8: word-address width; memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  clock; all memory writes occur on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- alu_op  input  2  ALU op from main control.
- func_code  input  6  instruction[5:0].
- alu_in_a  input  32  operand A (rs data).
- alu_in_b  input  32  operand B (ALUsrc mux output).
- mem_read  input  1  data-memory read enable.
- mem_write  input  1  data-memory write enable.
- write_data  input  32  store data (rt data).
- alu_ctrl  output  4  decoded ALU operation.
- alu_out  output  32  ALU result; also the memory byte address.
- zero  output  1  high when alu_out == 0.
- read_data  output  32  memory read data.

## Operation
ALU-control decode (combinational):
- alu_op 00 -> 0010 (add; lw/sw address).
- alu_op 01 -> 0110 (sub; beq).
- alu_op 11 -> 0001 (or; ori).
- alu_op 10 decodes func_code:
  - 100000 -> 0010 add
  - 100010 -> 0110 sub
  - 100100 -> 0000 and
  - 100101 -> 0001 or
  - 100111 -> 1100 nor
  - 101010 -> 0111 slt
  - any other -> 1111 invalid

ALU (combinational, driven by alu_ctrl):
- 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 1100 ~(A|B).
- 0111: 32'd1 if $signed(A) < $signed(B), else 0.
- Any other code, including 1111: result 0.
- Add/sub are modulo 2^32; no overflow flag, no trap.
- zero = (alu_out == 32'd0); asserted for invalid codes.

Data memory:
- 2^ADDR_W x 32 words.
- Word index = alu_out[ADDR_W+1:2]; bits [1:0] ignored (no alignment fault).
- Bits above ADDR_W+1 ignored, so addresses wrap.
- read_data = mem_read ? mem[index] : 32'd0, combinational.
- Write: on posedge clk with mem_write=1 and rst_n=1, mem[index] <= write_data.

## Timing
- Decode, ALU, zero and read path are purely combinational, with zero-cycle latency from inputs.
- Writes commit at the rising clk edge. A read of the same word in the same cycle returns the old value before the edge and the new value after it.
- mem_read and mem_write may both be asserted: the write happens, and read_data follows the rule above.
- rst_n low asynchronously clears every memory word to 0, and blocks writes while low. Reset asserted mid-write wins: the word holds 0.
- Reset values: read_data = 0. alu_ctrl, alu_out and zero are combinational functions of their inputs and are unaffected by reset.
- No handshake; the surrounding single-cycle datapath must hold inputs stable across the clock edge.

## Test plan
- Reset: pulse rst_n low asynchronously, then alu_op=00, A=0, B=0x40, mem_read=1 -> alu_out=0x40, read_data=0; repeat at several addresses -> all read 0.
- R-type decode: alu_op=10 with func 100000/100010/100100/100101/100111/101010, A=0x0000000C, B=0x0000000A -> alu_ctrl 0010/0110/0000/0001/1100/0111 and alu_out 0x16/0x2/0x8/0xE/0xFFFFFFF1/0.
- Signed slt: A=0xFFFFFFFF, B=1 -> alu_out=1; A=1, B=0xFFFFFFFF -> 0. Invalid func 000000 -> alu_ctrl=1111, alu_out=0, zero=1.
- Branch compare: alu_op=01, A=B=0x1234 -> alu_out=0, zero=1; A=0x1235 -> alu_out=1, zero=0. Add wrap: alu_op=00, A=0xFFFFFFFF, B=1 -> alu_out=0, zero=1.
- Store then load: alu_op=00, A=0x100, B=0x8, write_data=0xDEADBEEF, mem_write=1 for one edge. Then mem_write=0, mem_read=1 -> read_data=0xDEADBEEF. Address 0x10B reads the same word. With ADDR_W=8, address 0x508 wraps to the same word. mem_read=0 -> read_data=0.
- Reset during write: assert mem_write with rst_n low across an edge -> no write; after release, the word reads 0.
